// File: rtl/pic_ack_sequencer.sv
// INTA# acknowledge sequencer for an 8259-style PIC: walks IDLE/ACK1/ACK2,
// issues ISR set/clear pulses, drives the vector byte and cascade ID lines.
module pic_ack_sequencer #(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       interrupt_acknowledge_n,
  input  logic       write_initial_command_word_1,
  input  logic       single_or_cascade_config,
  input  logic       cascade_slave,
  input  logic       cascade_slave_enable,
  input  logic       auto_eoi_config,
  input  logic [7:0] cascade_device_config,
  input  logic [4:0] interrupt_vector_base,
  input  logic [7:0] highest_level_request,
  output logic [1:0] control_state,
  output logic [7:0] acknowledge_interrupt,
  output logic [7:0] in_service_set,
  output logic [7:0] end_of_interrupt_clear,
  output logic       out_control_logic_data,
  output logic [7:0] control_logic_data,
  output logic [2:0] cascade_out,
  output logic       cascade_out_enable,
  output logic       end_of_acknowledge_sequence
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACK1 = 2'b01,
    ST_ACK2 = 2'b10
  } state_t;

  state_t     r_state,  w_state_next;
  logic       r_inta_prev;
  logic       r_isr_issued, w_isr_issued_next;
  logic [7:0] r_ack,      w_ack_next;
  logic [7:0] r_isr_set,  w_isr_set_next;
  logic [7:0] r_eoi_clr,  w_eoi_clr_next;
  logic       r_eoa,      w_eoa_next;
  logic       r_data_oe,  w_data_oe_next;
  logic [7:0] r_data,     w_data_next;
  logic [2:0] r_cas_out,  w_cas_out_next;
  logic       r_cas_en,   w_cas_en_next;

  logic       w_fall, w_rise, w_owned, w_slave_level;
  logic [2:0] w_irq_index;

  function automatic logic [2:0] encode_level(input logic [7:0] level);
    logic [2:0] idx;
    idx = SPURIOUS_LEVEL;
    for (int i = 0; i < 8; i++) begin
      if (level[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign w_fall = r_inta_prev & ~interrupt_acknowledge_n;
  assign w_rise = ~r_inta_prev & interrupt_acknowledge_n;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    w_state_next      = r_state;
    w_ack_next        = r_ack;
    w_isr_issued_next = r_isr_issued;
    w_isr_set_next    = 8'h00;
    w_eoi_clr_next    = 8'h00;
    w_eoa_next        = 1'b0;

    if (write_initial_command_word_1) begin
      w_state_next      = ST_IDLE;
      w_ack_next        = 8'h00;
      w_isr_issued_next = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (w_fall) begin
          w_state_next      = ST_ACK1;
          w_ack_next        = highest_level_request;
          w_isr_issued_next = 1'b0;
        end
        ST_ACK1: if (w_fall) begin
          w_state_next = ST_ACK2;
        end else if (w_rise && (r_ack != 8'h00)
                     && (!cascade_slave || cascade_slave_enable)) begin
          w_isr_set_next    = r_ack;
          w_isr_issued_next = 1'b1;
        end
        ST_ACK2: if (w_rise) begin
          w_state_next = ST_IDLE;
          w_eoa_next   = 1'b1;
          if (auto_eoi_config && r_isr_issued) w_eoi_clr_next = r_ack;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end

    // Everything below looks at the level that will be latched next cycle.
    w_irq_index   = encode_level(w_ack_next);
    w_slave_level = |(w_ack_next & cascade_device_config);
    if (single_or_cascade_config) w_owned = 1'b1;
    else if (cascade_slave)       w_owned = cascade_slave_enable;
    else                          w_owned = ~w_slave_level;

    w_data_oe_next = (w_state_next == ST_ACK2) && !interrupt_acknowledge_n && w_owned;
    w_cas_en_next  = (w_state_next != ST_IDLE) && !single_or_cascade_config
                     && !cascade_slave && w_slave_level;
    w_cas_out_next = w_cas_en_next ? w_irq_index : 3'b000;

    if (write_initial_command_word_1)  w_data_next = 8'h00;
    else if (w_state_next != ST_IDLE)  w_data_next = {interrupt_vector_base, w_irq_index};
    else                               w_data_next = r_data;
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      r_state      <= ST_IDLE;
      r_inta_prev  <= 1'b1;
      r_isr_issued <= 1'b0;
      r_ack        <= 8'h00;
      r_isr_set    <= 8'h00;
      r_eoi_clr    <= 8'h00;
      r_eoa        <= 1'b0;
      r_data_oe    <= 1'b0;
      r_data       <= 8'h00;
      r_cas_out    <= 3'b000;
      r_cas_en     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_inta_prev  <= interrupt_acknowledge_n;
      r_isr_issued <= w_isr_issued_next;
      r_ack        <= w_ack_next;
      r_isr_set    <= w_isr_set_next;
      r_eoi_clr    <= w_eoi_clr_next;
      r_eoa        <= w_eoa_next;
      r_data_oe    <= w_data_oe_next;
      r_data       <= w_data_next;
      r_cas_out    <= w_cas_out_next;
      r_cas_en     <= w_cas_en_next;
    end
  end

  assign control_state               = r_state;
  assign acknowledge_interrupt       = r_ack;
  assign in_service_set              = r_isr_set;
  assign end_of_interrupt_clear      = r_eoi_clr;
  assign out_control_logic_data      = r_data_oe;
  assign control_logic_data          = r_data;
  assign cascade_out                 = r_cas_out;
  assign cascade_out_enable          = r_cas_en;
  assign end_of_acknowledge_sequence = r_eoa;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Self-checking bench for pic_ack_sequencer: directed INTA sequences followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_pic_ack_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       interrupt_acknowledge_n;
  logic       write_initial_command_word_1;
  logic       single_or_cascade_config;
  logic       cascade_slave;
  logic       cascade_slave_enable;
  logic       auto_eoi_config;
  logic [7:0] cascade_device_config;
  logic [4:0] interrupt_vector_base;
  logic [7:0] highest_level_request;
  logic [1:0] control_state;
  logic [7:0] acknowledge_interrupt;
  logic [7:0] in_service_set;
  logic [7:0] end_of_interrupt_clear;
  logic       out_control_logic_data;
  logic [7:0] control_logic_data;
  logic [2:0] cascade_out;
  logic       cascade_out_enable;
  logic       end_of_acknowledge_sequence;

  pic_ack_sequencer dut (
    .clock                       (clock),
    .reset                       (reset),
    .interrupt_acknowledge_n     (interrupt_acknowledge_n),
    .write_initial_command_word_1(write_initial_command_word_1),
    .single_or_cascade_config    (single_or_cascade_config),
    .cascade_slave               (cascade_slave),
    .cascade_slave_enable        (cascade_slave_enable),
    .auto_eoi_config             (auto_eoi_config),
    .cascade_device_config       (cascade_device_config),
    .interrupt_vector_base       (interrupt_vector_base),
    .highest_level_request       (highest_level_request),
    .control_state               (control_state),
    .acknowledge_interrupt       (acknowledge_interrupt),
    .in_service_set              (in_service_set),
    .end_of_interrupt_clear      (end_of_interrupt_clear),
    .out_control_logic_data      (out_control_logic_data),
    .control_logic_data          (control_logic_data),
    .cascade_out                 (cascade_out),
    .cascade_out_enable          (cascade_out_enable),
    .end_of_acknowledge_sequence (end_of_acknowledge_sequence)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase counts INTA falls seen in the current sequence (0..2).
  int         m_phase;
  bit         m_prev;
  bit         m_issued;
  logic [7:0] m_ack, e_isr, e_eoi, e_data;
  logic       e_eoa, e_oe, e_cas_en;
  logic [2:0] e_cas_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] level_index(input logic [7:0] lvl);
    int idx;
    logic [7:0] tmp;
    if (lvl == 8'h00) return 3'd7;
    idx = 0;
    tmp = lvl;
    while (tmp > 8'h01) begin
      tmp = tmp >> 1;
      idx++;
    end
    return 3'(idx);
  endfunction

  task automatic model_step();
    bit fall, rise, owned, to_slave;
    logic [2:0] idx;
    fall  = m_prev && !interrupt_acknowledge_n;
    rise  = !m_prev && interrupt_acknowledge_n;
    e_isr = 8'h00;
    e_eoi = 8'h00;
    e_eoa = 1'b0;
    if (reset) begin
      m_prev = 1'b1; m_phase = 0; m_ack = 8'h00; m_issued = 1'b0;
      e_data = 8'h00; e_oe = 1'b0; e_cas_en = 1'b0; e_cas_out = 3'b000;
      return;
    end
    m_prev = interrupt_acknowledge_n;
    if (write_initial_command_word_1) begin
      m_phase = 0; m_ack = 8'h00; m_issued = 1'b0;
      e_data = 8'h00; e_oe = 1'b0; e_cas_en = 1'b0; e_cas_out = 3'b000;
      return;
    end
    if (m_phase == 0 && fall) begin
      m_phase = 1; m_ack = highest_level_request; m_issued = 1'b0;
    end else if (m_phase == 1 && fall) begin
      m_phase = 2;
    end else if (m_phase == 1 && rise) begin
      if (m_ack != 0 && (!cascade_slave || cascade_slave_enable)) begin
        e_isr = m_ack; m_issued = 1'b1;
      end
    end else if (m_phase == 2 && rise) begin
      m_phase = 0; e_eoa = 1'b1;
      if (auto_eoi_config && m_issued) e_eoi = m_ack;
    end
    idx      = level_index(m_ack);
    to_slave = (m_ack & cascade_device_config) != 0;
    owned    = single_or_cascade_config ? 1'b1 :
               cascade_slave ? cascade_slave_enable : !to_slave;
    e_oe      = (m_phase == 2) && !interrupt_acknowledge_n && owned;
    e_cas_en  = (m_phase != 0) && !single_or_cascade_config && !cascade_slave && to_slave;
    e_cas_out = e_cas_en ? idx : 3'b000;
    if (m_phase != 0) e_data = {interrupt_vector_base, idx};
  endtask

  task automatic compare_all();
    check("state",   32'(control_state),               32'(m_phase));
    check("ack",     32'(acknowledge_interrupt),       32'(m_ack));
    check("isr_set", 32'(in_service_set),              32'(e_isr));
    check("eoi_clr", 32'(end_of_interrupt_clear),      32'(e_eoi));
    check("eoa",     32'(end_of_acknowledge_sequence), 32'(e_eoa));
    check("data_oe", 32'(out_control_logic_data),      32'(e_oe));
    check("data",    32'(control_logic_data),          32'(e_data));
    check("cas_en",  32'(cascade_out_enable),          32'(e_cas_en));
    check("cas_out", 32'(cascade_out),                 32'(e_cas_out));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic step(input logic inta, input int n);
    interrupt_acknowledge_n = inta;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_cfg(input logic single, input logic slave, input logic slave_en,
                         input logic aeoi, input logic [7:0] icw3, input logic [4:0] base,
                         input logic [7:0] req);
    single_or_cascade_config = single;
    cascade_slave            = slave;
    cascade_slave_enable     = slave_en;
    auto_eoi_config          = aeoi;
    cascade_device_config    = icw3;
    interrupt_vector_base    = base;
    highest_level_request    = req;
  endtask

  initial begin
    int hold;
    m_prev = 1'b1; m_phase = 0; m_ack = 8'h00; m_issued = 1'b0;
    e_isr = 8'h00; e_eoi = 8'h00; e_eoa = 1'b0; e_data = 8'h00;
    e_oe = 1'b0; e_cas_en = 1'b0; e_cas_out = 3'b000;
    reset = 1'b1;
    write_initial_command_word_1 = 1'b0;
    interrupt_acknowledge_n = 1'b1;
    set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'b01000, 8'h04);
    step(1'b1, 2);
    check("rst_state", 32'(control_state), 32'd0);
    check("rst_data",  32'(control_logic_data), 32'd0);
    reset = 1'b0;
    step(1'b1, 2);

    // Single mode, request 04, base 01000.
    step(1'b0, 1);
    check("t1_ack1", 32'(control_state), 32'd1);
    step(1'b1, 1);
    check("t1_isr", 32'(in_service_set), 32'h04);
    step(1'b1, 1);
    step(1'b0, 2);
    check("t1_data", 32'(control_logic_data), 32'h42);
    check("t1_oe",   32'(out_control_logic_data), 32'd1);
    step(1'b1, 1);
    check("t1_eoa",  32'(end_of_acknowledge_sequence), 32'd1);
    check("t1_idle", 32'(control_state), 32'd0);
    step(1'b1, 2);

    // Cascaded master, level 3 wired to a slave.
    set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 8'h08, 5'b01000, 8'h08);
    step(1'b0, 1);
    check("t2_cas_en",  32'(cascade_out_enable), 32'd1);
    check("t2_cas_out", 32'(cascade_out), 32'd3);
    step(1'b1, 2);
    step(1'b0, 2);
    check("t2_oe", 32'(out_control_logic_data), 32'd0);
    check("t2_cas_out2", 32'(cascade_out), 32'd3);
    step(1'b1, 3);

    // Slave with AEOI, base 10000, request 01.
    set_cfg(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 5'b10000, 8'h01);
    step(1'b0, 2);
    step(1'b1, 1);
    check("t3_isr", 32'(in_service_set), 32'h01);
    step(1'b0, 2);
    check("t3_data", 32'(control_logic_data), 32'h80);
    step(1'b1, 1);
    check("t3_eoi", 32'(end_of_interrupt_clear), 32'h01);
    step(1'b1, 2);

    // Spurious: no request at first fall.
    set_cfg(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'b01000, 8'h00);
    step(1'b0, 1);
    step(1'b1, 1);
    check("t4_isr", 32'(in_service_set), 32'h00);
    step(1'b0, 1);
    check("t4_data", 32'(control_logic_data), 32'h47);
    step(1'b1, 1);
    check("t4_eoi", 32'(end_of_interrupt_clear), 32'h00);
    step(1'b1, 2);

    // ICW1 abort in ACK1 while INTA is low, then the rise lands in IDLE.
    set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'b00100, 8'h20);
    step(1'b0, 1);
    write_initial_command_word_1 = 1'b1;
    step(1'b0, 1);
    write_initial_command_word_1 = 1'b0;
    check("t5_icw1_idle", 32'(control_state), 32'd0);
    step(1'b1, 1);
    check("t5_rise_idle", 32'(control_state), 32'd0);
    check("t5_no_isr", 32'(in_service_set), 32'h00);
    // Reset abort in ACK1, then a clean restart.
    step(1'b0, 1);
    reset = 1'b1;
    step(1'b1, 1);
    reset = 1'b0;
    check("t5_rst_idle", 32'(control_state), 32'd0);
    step(1'b1, 1);
    step(1'b0, 1);
    step(1'b1, 1);
    check("t5_restart_isr", 32'(in_service_set), 32'h20);
    step(1'b0, 1);
    step(1'b1, 3);

    // Randomized traffic.
    hold = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) begin
        single_or_cascade_config = 1'($urandom_range(0, 1));
        cascade_slave            = 1'($urandom_range(0, 1));
        auto_eoi_config          = 1'($urandom_range(0, 1));
        cascade_device_config    = 8'($urandom);
        interrupt_vector_base    = 5'($urandom);
      end
      hold--;
      if (hold <= 0) begin
        interrupt_acknowledge_n = ~interrupt_acknowledge_n;
        hold = $urandom_range(1, 4);
      end
      cascade_slave_enable = 1'($urandom_range(0, 1));
      begin
        int k;
        k = $urandom_range(0, 8);
        highest_level_request = (k == 8) ? 8'h00 : 8'(1 << k);
      end
      write_initial_command_word_1 = ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0;
    write_initial_command_word_1 = 1'b0;
    step(1'b1, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
